// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared loader states and memory geometry constants
package rom_loader_pkg;

    // Stream side delivers bytes; the target RAM stores 16-bit words.
    localparam int BYTE_WIDTH    = 8;
    localparam int WORD_WIDTH    = 16;
    localparam int DEFAULT_DEPTH = 16384;

    // Loader sequencing: one high byte, one low byte, one write cycle per word.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_HI = 3'd1,
        ST_LOAD_LO = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } loader_state_e;

    // Words arrive big-endian: the first byte of each pair is the high byte.
    function automatic logic [WORD_WIDTH-1:0] pack_word(
        input logic [BYTE_WIDTH-1:0] hi,
        input logic [BYTE_WIDTH-1:0] lo
    );
        return {hi, lo};
    endfunction

endpackage

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - byte-stream to 16-bit RAM image loader with CPU reset hold
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [BYTE_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0]    mem_din,
    output logic                     mem_we,
    output logic                     busy,
    output logic                     done,
    output logic                     cpu_reset
);

    // Address of the final word; the counter stops here instead of wrapping,
    // which matters when DEPTH is not a power of two.
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    loader_state_e             state_q;
    logic [ADDRESS_WIDTH-1:0]  counter_q;
    logic [BYTE_WIDTH-1:0]     hi_q;
    logic                      in_ready_q;
    logic [ADDRESS_WIDTH-1:0]  mem_addr_q;
    logic [WORD_WIDTH-1:0]     mem_din_q;
    logic                      mem_we_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      cpu_reset_q;

    // A byte moves only when both sides agree; in_ready_q is a flop, so there
    // is no combinational path from in_valid back to in_ready.
    logic byte_xfer;
    assign byte_xfer = in_valid & in_ready_q;

    // Loader FSM; every output is registered alongside the state it belongs to.
    // The low byte is not kept separately: it goes straight into mem_din_q on
    // the transfer edge, so the word is complete during the WRITE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            counter_q   <= '0;
            hi_q        <= '0;
            in_ready_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_LOAD_HI;
                        counter_q   <= '0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        cpu_reset_q <= 1'b1;
                    end
                end

                ST_LOAD_HI: begin
                    if (byte_xfer) begin
                        hi_q    <= in_data;
                        state_q <= ST_LOAD_LO;
                    end
                end

                ST_LOAD_LO: begin
                    if (byte_xfer) begin
                        state_q    <= ST_WRITE;
                        in_ready_q <= 1'b0;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= counter_q;
                        mem_din_q  <= pack_word(hi_q, in_data);
                    end
                end

                ST_WRITE: begin
                    mem_we_q <= 1'b0;
                    if (counter_q == LAST_ADDR) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b0;
                    end else begin
                        state_q    <= ST_LOAD_HI;
                        counter_q  <= counter_q + ADDRESS_WIDTH'(1);
                        in_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    mem_we_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    cpu_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cpu_reset = cpu_reset_q;

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter DEPTH, default 16384: number of 16-bit words to load.
REQ-002 Parameter ADDRESS_WIDTH, default $clog2(DEPTH): word address width.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle load request.
REQ-006 in_data  input  8  byte stream data, big-endian words (high byte first).
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_addr  output  ADDRESS_WIDTH  word write address.
REQ-010 mem_din  output  16  word write data.
REQ-011 mem_we  output  1  one-cycle write strobe.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  full image written.
REQ-014 cpu_reset  output  1  holds CPU in reset while not done.

Function
REQ-015 States: IDLE, LOAD_HI, LOAD_LO, WRITE, DONE.
REQ-016 Byte transfer occurs on a cycle with in_valid and in_ready both high; no other cycle consumes a byte.
REQ-017 in_ready SHALL be high exactly in LOAD_HI and LOAD_LO, registered from state, no combinational path from in_valid.
REQ-018 IDLE: start=1 -> LOAD_HI, word counter cleared to 0.
REQ-019 LOAD_HI: on transfer, latch in_data as high byte -> LOAD_LO; otherwise stay.
REQ-020 LOAD_LO: on transfer, latch in_data as low byte -> WRITE; otherwise stay.
REQ-021 WRITE lasts exactly one cycle: mem_we=1, mem_addr=counter, mem_din={high,low}.
REQ-022 After WRITE: counter=DEPTH-1 -> DONE; else counter+1 -> LOAD_HI.
REQ-023 Latency: mem_we asserted in the cycle immediately after the low-byte transfer; minimum 3 cycles per word.
REQ-024 Counter never exceeds DEPTH-1; non-power-of-two DEPTH terminates at DEPTH-1, no wrap.
REQ-025 mem_we SHALL be 0 in every state except WRITE; mem_addr/mem_din hold last values outside WRITE.
REQ-026 busy=1 in LOAD_HI, LOAD_LO, WRITE; 0 otherwise.
REQ-027 done=1 only in DONE; held until next start.
REQ-028 cpu_reset = not done, registered.
REQ-029 start while busy SHALL be ignored.
REQ-030 start in DONE -> LOAD_HI, counter 0, done drops next cycle, cpu_reset rises.
REQ-031 Bytes presented in IDLE, WRITE or DONE SHALL NOT be consumed (in_ready=0).

Reset
REQ-032 reset asserted at any time, including mid-word or mid-WRITE, SHALL force IDLE asynchronously.
REQ-033 Reset values: in_ready=0, mem_addr=0, mem_din=0, mem_we=0, busy=0, done=0, cpu_reset=1, counter=0, byte latches=0.
REQ-034 A partially assembled word at reset SHALL be discarded, never written.

Structure
REQ-035 State enumeration SHALL live in the shared package with other loader/memory constants.
REQ-036 Single flat module; no sub-module required.
REQ-037 mem_* ports SHALL connect directly to a synchronous single-port RAM write port of DATA_WIDTH 16 and depth DEPTH.

Verification
REQ-038 DEPTH=4, start, bytes 12 34 56 78 9A BC DE F0 continuous valid -> writes 0:1234,1:5678,2:9ABC,3:DEF0, each mem_we one cycle, done=1 after last, cpu_reset=0.
REQ-039 Same stream with in_valid toggled every other cycle -> identical writes, no byte dropped or duplicated.
REQ-040 start pulsed during LOAD_LO of word 1 -> ignored; counter and data unaffected.
REQ-041 reset asserted after byte AB of word 2 -> IDLE immediately, no write to addr 2, all outputs at reset values.
REQ-042 DEPTH=3, 6 bytes -> last write at addr 2, DONE; further valid bytes not consumed (in_ready=0).
REQ-043 From DONE, start and new stream 00 01 .. -> done drops, rewrite from addr 0 with new data.
